// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the fetch/data memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates an instruction-fetch port and a data port onto one
//            Avalon-MM master; one transaction in flight, fair or fixed grant.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    port_t       r_last_grant;
    port_t       r_port;
    port_t       w_grant;
    logic        w_take;
    logic        w_done;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_be;
    logic        w_unused;

    // Bus addresses are always word aligned; the byte offset bits are dropped.
    assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = PORT_I;
        w_take      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && d_req) begin
                    w_take = 1'b1;
                    if (FAIR != 0)
                        w_grant = (r_last_grant == PORT_D) ? PORT_I : PORT_D;
                    else
                        w_grant = PORT_D;
                end else if (i_req) begin
                    w_take  = 1'b1;
                    w_grant = PORT_I;
                end else if (d_req) begin
                    w_take  = 1'b1;
                    w_grant = PORT_D;
                end
                if (w_take)
                    w_state_nxt = (w_grant == PORT_I) ? BUS_I : BUS_D;
            end
            BUS_I, BUS_D: begin
                if (!waitrequest) begin
                    w_done      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= PORT_D;
            r_port       <= PORT_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            if (w_take) begin
                r_port <= w_grant;
                if (w_grant == PORT_I) begin
                    r_addr  <= {i_addr[31:2], 2'b00};
                    r_wdata <= '0;
                    r_we    <= 1'b0;
                    r_be    <= BE_ALL;
                end else begin
                    r_addr  <= {d_addr[31:2], 2'b00};
                    r_wdata <= d_wdata;
                    r_we    <= d_we;
                    r_be    <= d_be;
                end
            end
            if (w_done) begin
                r_last_grant <= r_port;
                if (r_state == BUS_I)
                    i_rdata <= readdata;
                else if (!r_we)
                    d_rdata <= readdata;
            end
        end
    end

    // A fetch is latched as a full-word load, so both bus states share one path.
    always_comb begin
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        if (r_state == BUS_I || r_state == BUS_D) begin
            address    = r_addr;
            read       = !r_we;
            write      = r_we;
            writedata  = r_wdata;
            byteenable = r_be;
        end
    end

    assign i_ack = (r_state == DONE) && (r_port == PORT_I);
    assign d_ack = (r_state == DONE) && (r_port == PORT_D);
    assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire
